// File: rtl/timebase_gen.sv
// timebase_gen: run-controlled prescaler with cascaded decade strobes.
//
// A prescaler counts 0..N-1 while running and unpaused, pulsing tick[0] on
// the cycle it wraps. Each further stage k is a decade counter that advances
// on tick[k-1] and pulses tick[k] when it wraps 9->0, so tick[k] fires once
// every 10^k prescaler periods, coincident with all lower strobes.
//
// Ports:
//   clk        in            single clock, rising edge
//   reset_n    in            synchronous active-low reset
//   start      in            pulse: IDLE/DONE -> RUN, clears counters, latches oneshot
//   stop       in            pulse: any state -> IDLE, clears counters
//   pause      in            level: freezes counting in RUN
//   oneshot    in            level, sampled on accepted start
//   div_load   in            pulse: captures div_value into the shadow divisor
//   div_value  in  [DIV_W]   new prescaler divisor (0 behaves as 1)
//   tick       out [STAGES]  one-cycle strobes, tick[0] = prescaler
//   busy       out           high in RUN (also while paused)
//   done       out           high in DONE
module timebase_gen #(
  parameter int unsigned DIV_W     = 18,
  parameter int unsigned DIV_RESET = 250000,
  parameter int unsigned STAGES    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              oneshot,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  output logic [STAGES-1:0] tick,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             oneshot_q, oneshot_d;
  // Element 0 is unused and held at zero; stage k lives at index k.
  logic [3:0]       dec_q [STAGES];
  logic [3:0]       dec_d [STAGES];

  logic [DIV_W-1:0] n_m1;
  logic             advance;

  // Strobe decode: all strobes come from registered counts qualified by the
  // cycle actually advancing, so a pause or stop in a wrap cycle kills it.
  always_comb begin : strobe_decode
    logic carry;
    n_m1    = (active_q == '0) ? '0 : active_q - DIV_W'(1);
    advance = (state_q == StRun) && !stop && !pause;
    carry   = advance && (presc_q == n_m1);
    tick    = '0;
    tick[0] = carry;
    for (int k = 1; k < STAGES; k++) begin
      carry   = carry && (dec_q[k] == 4'd9);
      tick[k] = carry;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    presc_d   = presc_q;
    dec_d     = dec_q;
    oneshot_d = oneshot_q;
    shadow_d  = div_load ? div_value : shadow_q;
    active_d  = active_q;

    if (stop) begin
      state_d = StIdle;
      presc_d = '0;
      for (int k = 0; k < STAGES; k++) dec_d[k] = '0;
    end else if (start && (state_q != StRun)) begin
      state_d   = StRun;
      presc_d   = '0;
      oneshot_d = oneshot;
      for (int k = 0; k < STAGES; k++) dec_d[k] = '0;
    end else if (advance) begin
      presc_d = tick[0] ? '0 : presc_q + DIV_W'(1);
      for (int k = 1; k < STAGES; k++) begin
        if (tick[k-1]) dec_d[k] = tick[k] ? 4'd0 : dec_q[k] + 4'd1;
      end
      // The wrap itself used the old divisor; a load in this same cycle
      // (already in shadow_d) governs the following period.
      if (tick[0]) active_d = shadow_d;
      if (tick[STAGES-1] && oneshot_q) begin
        state_d = StDone;
        presc_d = '0;
        for (int k = 0; k < STAGES; k++) dec_d[k] = '0;
      end
    end

    // Outside RUN there is no period in flight, so loads apply at once.
    if (state_q != StRun) active_d = shadow_d;

    dec_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      active_q  <= DIV_W'(DIV_RESET);
      shadow_q  <= DIV_W'(DIV_RESET);
      oneshot_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) dec_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      oneshot_q <= oneshot_d;
      for (int k = 0; k < STAGES; k++) dec_q[k] <= dec_d[k];
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen with DIV_W=8, STAGES=2, DIV_RESET=7.
// Cycle c=0 is the cycle in which start is held high; with divisor N the
// prescaler strobes at c = N, 2N, ... and tick[1] on every tenth strobe.
module tb_timebase_gen;

  localparam int unsigned DIV_W     = 8;
  localparam int unsigned DIV_RESET = 7;
  localparam int unsigned STAGES    = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start, stop, pause, oneshot, div_load;
  logic [DIV_W-1:0] div_value;
  logic [1:0]       tick;
  logic             busy, done;

  int n_cmp = 0;
  int n_err = 0;

  timebase_gen #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET),
    .STAGES    (STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .oneshot   (oneshot),
    .div_load  (div_load),
    .div_value (div_value),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Move just past the next rising edge and drop all pulse inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    start    = 1'b0;
    stop     = 1'b0;
    div_load = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [1:0] et, input logic eb, input logic ed);
    #1;
    n_cmp++;
    assert ({tick, busy, done} === {et, eb, ed}) else begin
      n_err++;
      $error("FAIL %s: got tick=%b busy=%b done=%b, want tick=%b busy=%b done=%b",
             tag, tick, busy, done, et, eb, ed);
    end
  endtask

  task automatic load_idle(input int v);
    cyc();
    div_load  = 1'b1;
    div_value = DIV_W'(v);
    chk("load_idle", 2'b00, 1'b0, 1'b0);
  endtask

  task automatic stop_run(input string tag);
    cyc();
    stop = 1'b1;
    cyc();
    chk(tag, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    pause     = 1'b0;
    oneshot   = 1'b0;
    div_load  = 1'b0;
    div_value = '0;

    // Held in reset: everything quiet even with start pulsed.
    for (int i = 0; i < 3; i++) begin
      cyc();
      start = (i == 1);
      chk($sformatf("reset c%0d", i), 2'b00, 1'b0, 1'b0);
    end
    reset_n = 1'b1;

    // Divisor from reset (7).
    for (int c = 0; c <= 15; c++) begin
      cyc();
      start = (c == 0);
      chk($sformatf("rstdiv c%0d", c), {1'b0, c > 0 && c % 7 == 0}, c > 0, 1'b0);
    end
    stop_run("rstdiv_stop");

    // N=4 periodic, tick[1] at 40; start at c=42 is ignored.
    load_idle(4);
    for (int c = 0; c <= 45; c++) begin
      cyc();
      start = (c == 0) || (c == 42);
      chk($sformatf("n4 c%0d", c), {c == 40, c > 0 && c % 4 == 0}, c > 0, 1'b0);
    end
    stop_run("n4_stop");

    // N=3 oneshot: top strobe at 30, DONE from 31, then restart.
    load_idle(3);
    for (int c = 0; c <= 35; c++) begin
      cyc();
      start   = (c == 0);
      oneshot = (c == 0);
      chk($sformatf("oneshot c%0d", c), {c == 30, c >= 1 && c <= 30 && c % 3 == 0},
          c >= 1 && c <= 30, c >= 31);
    end
    for (int c = 0; c <= 4; c++) begin
      cyc();
      start   = (c == 0);
      oneshot = 1'b0;
      chk($sformatf("restart c%0d", c), {1'b0, c == 3}, c >= 1, c == 0);
    end
    stop_run("restart_stop");

    // N=5 with pause 2..4 (delays first strobe to 8) and 13..15 (holds at N-1).
    load_idle(5);
    for (int c = 0; c <= 22; c++) begin
      cyc();
      start = (c == 0);
      pause = (c >= 2 && c <= 4) || (c >= 13 && c <= 15);
      chk($sformatf("pause c%0d", c), {1'b0, c == 8 || c == 16 || c == 21}, c >= 1, 1'b0);
    end
    pause = 1'b0;
    stop_run("pause_stop");

    // Divisor change mid-run: load 6 at c=2, then a load coincident with the wrap at c=4.
    for (int pass = 0; pass < 2; pass++) begin
      load_idle(4);
      for (int c = 0; c <= 17; c++) begin
        cyc();
        start = (c == 0);
        if (c == (pass == 0 ? 2 : 4)) begin
          div_load  = 1'b1;
          div_value = 8'd6;
        end
        chk($sformatf("divchg%0d c%0d", pass, c), {1'b0, c == 4 || c == 10 || c == 16},
            c >= 1, 1'b0);
      end
      stop_run("divchg_stop");
    end

    // Divisor 0 behaves as 1: strobe every running cycle.
    load_idle(0);
    for (int c = 0; c <= 12; c++) begin
      cyc();
      start = (c == 0);
      chk($sformatf("n0 c%0d", c), {c == 10, c >= 1}, c >= 1, 1'b0);
    end
    stop_run("n0_stop");

    // start and stop together: stop wins.
    cyc();
    start = 1'b1;
    stop  = 1'b1;
    chk("startstop c0", 2'b00, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("startstop c%0d", i), 2'b00, 1'b0, 1'b0);
    end

    // Reset mid-run, then the divisor is back to 7.
    load_idle(3);
    for (int c = 0; c <= 6; c++) begin
      cyc();
      start   = (c == 0);
      reset_n = (c != 5);
      chk($sformatf("midrst c%0d", c), {1'b0, c == 3}, c >= 1 && c <= 5, 1'b0);
    end
    for (int c = 0; c <= 8; c++) begin
      cyc();
      start = (c == 0);
      chk($sformatf("postrst c%0d", c), {1'b0, c == 7}, c >= 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Parameters
REQ-001 SHALL: DIV_W, default 18, width of prescaler divisor and counter.
REQ-002 SHALL: DIV_RESET, default 250000, divisor loaded at reset (0.01 s at 25 MHz).
REQ-003 SHALL: STAGES, default 3, range 1..4, number of strobe outputs (prescaler plus STAGES-1 decade stages).

Interface
REQ-004 SHALL: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL: reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL: start  in  1  one-cycle pulse; IDLE/DONE -> RUN.
REQ-007 SHALL: stop  in  1  one-cycle pulse; any state -> IDLE, counters cleared.
REQ-008 SHALL: pause  in  1  level; while high in RUN, all counters hold and no strobes fire.
REQ-009 SHALL: oneshot  in  1  level, sampled on accepted start; 1 = stop after first top-stage strobe.
REQ-010 SHALL: div_load  in  1  one-cycle pulse; captures div_value into shadow register.
REQ-011 SHALL: div_value  in  DIV_W  new prescaler divisor N.
REQ-012 SHALL: tick  out  STAGES  tick[0] prescaler strobe; tick[k] = every 10^k prescaler strobes; one-cycle pulses.
REQ-013 SHALL: busy  out  1  high in RUN (including paused).
REQ-014 SHALL: done  out  1  high in DONE.

Function
REQ-015 SHALL: FSM states IDLE, RUN, DONE; registered state, single always-edge update.
REQ-016 SHALL: IDLE --start--> RUN; RUN --stop--> IDLE; RUN --top strobe with latched oneshot=1--> DONE; DONE --start--> RUN; DONE --stop--> IDLE.
REQ-017 SHALL: priority per cycle: reset_n low > stop > start > counting.
REQ-018 SHALL: start while in RUN ignored (no restart, no counter change).
REQ-019 SHALL: accepted start clears prescaler and all decade counters and latches oneshot.
REQ-020 SHALL: prescaler counts 0..N-1 when RUN and pause low; tick[0] asserted combinationally-free (registered or decoded from count) in the cycle count==N-1 and advancing; count wraps to 0 that cycle.
REQ-021 SHALL: first tick[0] occur exactly N cycles after the start cycle (start in cycle 0, tick[0] in cycle N).
REQ-022 SHALL: effective divisor N = 1 when register holds 0; N=1 gives tick[0] every running cycle.
REQ-023 SHALL: decade stage k (1..STAGES-1) count 0..9, advance on tick[k-1], wrap 9->0 asserting tick[k] in the same cycle as tick[k-1].
REQ-024 SHALL: div_load write shadow register; active divisor updated from shadow at next prescaler wrap, or immediately when not RUN.
REQ-025 SHALL: div_load and wrap in same cycle: wrap uses old active divisor, new value applies from next period.
REQ-026 SHALL: pause ignored outside RUN; pause during tick cycle suppresses that tick (count holds at N-1).
REQ-027 SHALL: in DONE, counters hold at zero, tick all zero.
REQ-028 SHALL: top-stage strobe entering DONE still be output as a single pulse.

Reset
REQ-029 SHALL: reset_n low at a clock edge: state IDLE, prescaler and decade counters 0, active and shadow divisor DIV_RESET, latched oneshot 0.
REQ-030 SHALL: during and after reset tick=0, busy=0, done=0 until start.
REQ-031 SHALL: reset mid-RUN take effect at that edge, discarding partial counts.

Verification
REQ-032 SHALL: DIV_W=8, N=4, STAGES=2, periodic start at cycle 0 -> tick[0] at cycles 4,8,...; tick[1] at cycle 40 coincident with tick[0].
REQ-033 SHALL: N=3, oneshot=1, STAGES=2 -> tick[1] at cycle 30, done=1 from cycle 31, busy=0, no further ticks; start -> RUN again.
REQ-034 SHALL: N=5, pause high cycles 2..4 -> first tick[0] at cycle 8; pause at count 4 suppresses tick until release.
REQ-035 SHALL: running N=4, div_load 6 at cycle 2 -> ticks at 4, 10, 16; div_load coincident with wrap at cycle 4 -> next tick at 10.
REQ-036 SHALL: div_value 0 loaded in IDLE, start -> tick[0] every running cycle.
REQ-037 SHALL: start and stop same cycle -> IDLE; reset_n low mid-RUN -> all outputs 0 next cycle, divisor DIV_RESET.
